cache_ctrl_direct: RTL and testbench
====================================

// Module: cache_ctrl_direct
// PURPOSE
//  CPU-side direct-mapped cache controller. It is the initiator end of the mem_req/mem_ready
//  RAM handshake (1024 x 10-bit words, 20-bit two-word line bus, inout data).
//  Serves 10-bit CPU word reads/writes from a local line store. Misses and writes go to the RAM.
//  Policy: write-through, write-allocate. Tracks hit/miss statistics.
// PARAMETERS
//  INDEX_BITS  3   line index width; 2**INDEX_BITS lines of 20 bits; tag = 9-INDEX_BITS bits
//  CNT_W       16  width of hit/miss counters
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  cpu_req    in   1      CPU request; sampled only in IDLE
//  cpu_we     in   1      1=write, 0=read
//  cpu_addr   in   10     word address: [0]=word-in-line, [INDEX_BITS:1]=index, [9:INDEX_BITS+1]=tag
//  cpu_wdata  in   10     write word
//  cpu_rdata  out  10     read word, valid when cpu_ready rises after a read
//  cpu_ready  out  1      1=idle/done; 0=busy
//  mem_req    out  1      one-cycle request pulse to RAM
//  mem_we     out  1      RAM write enable, held for whole transaction
//  mem_addr   out  10     line address {tag,index,1'b0}, held for whole transaction
//  mem_data   inout 20    driven when mem_we=1 ({word1,word0}); else 'z (RAM drives)
//  mem_ready  in   1      RAM ready; drops 1 cycle after accepting req, rises on completion
//  hit_cnt    out  CNT_W  saturating count of LOOKUP hits
//  miss_cnt   out  CNT_W  saturating count of LOOKUP misses
// BEHAVIOUR
//  Reset (async): state=IDLE, all valid bits=0, cpu_ready=1, cpu_rdata=0, mem_req=0, mem_we=0,
//   mem_addr=0, mem_data='z, counters=0. Line data/tags need no reset.
//  All outputs are registered.
//  FSM: IDLE, LOOKUP, RD_REQ, RD_ACK, RD_DONE, WR_REQ, WR_ACK, WR_DONE.
//  IDLE: cpu_req=1 -> latch addr/we/wdata, cpu_ready<=0, go LOOKUP.
//   cpu_req outside IDLE is ignored.
//  LOOKUP: hit = valid[idx] && tag==stored tag; increment the matching counter (saturate at all-ones).
//   read hit  -> cpu_rdata<=line word, cpu_ready<=1, IDLE.
//   write hit -> merge wdata into cached line, go WR_REQ.
//   any miss  -> RD_REQ.
//  RD_REQ/WR_REQ: mem_req=1 for exactly this cycle; mem_addr and mem_we are set here.
//   Next state is RD_ACK/WR_ACK.
//  *_ACK: wait while mem_ready=1; on mem_ready=0 go *_DONE.
//  *_DONE: wait while mem_ready=0; on mem_ready=1 complete:
//   RD_DONE: line<=mem_data, tag<=addr tag, valid<=1.
//    If read: cpu_rdata<=word, cpu_ready<=1, IDLE.
//    If write: merge wdata into the line, go WR_REQ.
//   WR_DONE: cpu_ready<=1, IDLE; release mem_we (bus back to 'z).
//  mem_we, mem_addr and the driven data stay stable from *_REQ through *_DONE.
//  mem_req never stays high 2 consecutive cycles; with a 1-wait RAM it is never reasserted before completion.
//  Latency (cpu_ready low cycles, 1-wait RAM): read hit 1, read miss 4, write hit 4, write miss 7.
//  Word select: cpu_addr[0]=0 -> bits[9:0], 1 -> bits[19:10].
//  Conflict miss overwrites the line silently; no dirty state, because write-through.
//  Reset mid-transaction: controller returns to IDLE at once and the bus goes 'z.
//   A RAM transaction already accepted still completes in the RAM. Software must not depend on it.
// TESTING (pair with ramtask1_for_cache; RAM[0]=22, RAM[1]=10, RAM[2]=21, RAM[3]=0, RAM[16]=15)
//  1. Reset, read 0x000 -> miss; mem_req one pulse, mem_addr=0x000;
//     cpu_ready low 4 cycles; cpu_rdata=22; miss_cnt=1.
//  2. Then read 0x001 -> hit, no mem_req, cpu_ready low 1 cycle; cpu_rdata=10; hit_cnt=1.
//  3. Write 0x002=0x155 -> miss then write; 7 busy cycles; RAM[2]=0x155 and RAM[3]=0.
//     Then read 0x003 -> hit, cpu_rdata=0.
//  4. Read 0x010 (same index 0) -> miss, cpu_rdata=15; then read 0x000 -> miss again, cpu_rdata=22.
//  5. Write hit 0x001=0x3FF -> 4 busy cycles, mem_data=={0x3FF,22} while mem_we=1; RAM[1]=0x3FF.
//  6. rst_n low during RD_ACK -> mem_req=0, mem_we=0, cpu_ready=1 immediately.
//     After release, read 0x001 misses (valid cleared).

Source files
------------

// File: rtl/cache_ctrl_direct.sv
// Direct-mapped, write-through / write-allocate cache between a 10-bit CPU port and a 20-bit line RAM.
// Latency (cpu_ready low, 1-wait RAM): read hit 1, read miss 4, write hit 4, write miss 7 cycles.
// Backpressure: cpu_ready=0 while busy (cpu_req ignored); RAM side waits on mem_ready low->high.
module cache_ctrl_direct #(
  parameter int INDEX_BITS = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [9:0]       cpu_addr,
  input  logic [9:0]       cpu_wdata,
  output logic [9:0]       cpu_rdata,
  output logic             cpu_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [9:0]       mem_addr,
  inout  wire  [19:0]      mem_data,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int TAG_W = 9 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, RD_REQ, RD_ACK, RD_DONE, WR_REQ, WR_ACK, WR_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         addr_q, addr_d;
  logic               we_q, we_d;
  logic [9:0]         wdata_q, wdata_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [9:0]         cpu_rdata_q, cpu_rdata_d;
  logic               cpu_ready_q, cpu_ready_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [9:0]         mem_addr_q, mem_addr_d;
  logic [19:0]        mem_wdat_q, mem_wdat_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  // Line store: data and tags carry no reset, the valid bits guard them.
  logic [19:0]        line_mem [LINES];
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic               line_we;
  logic               tag_we;
  logic [19:0]        line_wdat;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  word_sel;
  logic [19:0]           cur_line;
  logic                  hit;
  logic [9:0]            line_addr;

  assign idx       = addr_q[INDEX_BITS:1];
  assign tag       = addr_q[9:INDEX_BITS+1];
  assign word_sel  = addr_q[0];
  assign cur_line  = line_mem[idx];
  assign hit       = valid_q[idx] && (tag_mem[idx] == tag);
  assign line_addr = {addr_q[9:1], 1'b0};

  // Replace one word of a line with the CPU write word.
  function automatic logic [19:0] merge_word(input logic [19:0] line,
                                             input logic        sel,
                                             input logic [9:0]  w);
    logic [19:0] r;
    r = line;
    if (sel) r[19:10] = w;
    else     r[9:0]   = w;
    return r;
  endfunction

  // Pick the addressed word out of a line.
  function automatic logic [9:0] pick_word(input logic [19:0] line, input logic sel);
    return sel ? line[19:10] : line[9:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Next-state and registered-output logic for the controller FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    valid_d     = valid_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = cpu_ready_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdat_d  = mem_wdat_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    line_we     = 1'b0;
    tag_we      = 1'b0;
    line_wdat   = cur_line;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d      = cpu_addr;
          we_d        = cpu_we;
          wdata_d     = cpu_wdata;
          cpu_ready_d = 1'b0;
          state_d     = LOOKUP;
        end
      end

      LOOKUP: begin
        if (hit) begin
          hit_cnt_d = sat_inc(hit_cnt_q);
          if (!we_q) begin
            cpu_rdata_d = pick_word(cur_line, word_sel);
            cpu_ready_d = 1'b1;
            state_d     = IDLE;
          end else begin
            // Write hit: update the cached line and push the whole line through.
            line_wdat  = merge_word(cur_line, word_sel, wdata_q);
            line_we    = 1'b1;
            mem_wdat_d = line_wdat;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = line_addr;
            state_d    = WR_REQ;
          end
        end else begin
          // Any miss fetches the line first, writes included (write-allocate).
          miss_cnt_d = sat_inc(miss_cnt_q);
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = line_addr;
          state_d    = RD_REQ;
        end
      end

      RD_REQ: state_d = RD_ACK;
      WR_REQ: state_d = WR_ACK;

      RD_ACK: if (!mem_ready) state_d = RD_DONE;
      WR_ACK: if (!mem_ready) state_d = WR_DONE;

      RD_DONE: begin
        if (mem_ready) begin
          tag_we       = 1'b1;
          line_we      = 1'b1;
          valid_d[idx] = 1'b1;
          if (!we_q) begin
            line_wdat   = mem_data;
            cpu_rdata_d = pick_word(mem_data, word_sel);
            cpu_ready_d = 1'b1;
            state_d     = IDLE;
          end else begin
            // Allocated line gets the CPU word merged, then the write-through starts.
            line_wdat  = merge_word(mem_data, word_sel, wdata_q);
            mem_wdat_d = line_wdat;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b1;
            state_d    = WR_REQ;
          end
        end
      end

      WR_DONE: begin
        if (mem_ready) begin
          mem_we_d    = 1'b0;
          cpu_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction and floats the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      valid_q     <= '0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdat_q  <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      valid_q     <= valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdat_q  <= mem_wdat_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Line data and tag storage.
  always_ff @(posedge clk) begin
    if (line_we) line_mem[idx] <= line_wdat;
    if (tag_we)  tag_mem[idx]  <= tag;
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign mem_data  = mem_we_q ? mem_wdat_q : {20{1'bz}};

endmodule

// File: tb/tb_cache_ctrl_direct.sv
// Bench for cache_ctrl_direct: directed scenarios, then random traffic vs. a flat memory model.
// Latency is checked against the 1-wait table whenever the RAM runs with no extra wait.
// The RAM model may insert extra wait cycles to stretch the handshake.
module tb_cache_ctrl_direct;

  localparam int CW = 4;  // small counters so saturation is reached

  logic          clk;
  logic          rst_n;
  logic          cpu_req;
  logic          cpu_we;
  logic [9:0]    cpu_addr;
  logic [9:0]    cpu_wdata;
  logic [9:0]    cpu_rdata;
  logic          cpu_ready;
  logic          mem_req;
  logic          mem_we;
  logic [9:0]    mem_addr;
  wire  [19:0]   mem_data;
  logic          mem_ready;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  cache_ctrl_direct #(.INDEX_BITS(3), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- RAM model (not reset by rst_n) ----------------
  logic [9:0]  ram [1024];
  logic        ram_busy;
  logic [19:0] ram_rdat;
  logic [9:0]  ram_a;
  logic        ram_we_l;
  logic [19:0] ram_wd;
  int          ram_wait_cfg;
  int          ram_wait_cnt;

  assign mem_data = mem_we ? {20{1'bz}} : ram_rdat;

  always @(posedge clk) begin
    if (!ram_busy) begin
      if (mem_req && mem_ready) begin
        ram_busy     <= 1'b1;
        mem_ready    <= 1'b0;
        ram_a        <= mem_addr;
        ram_we_l     <= mem_we;
        ram_wd       <= mem_data;
        ram_wait_cnt <= ram_wait_cfg;
      end
    end else if (ram_wait_cnt > 0) begin
      ram_wait_cnt <= ram_wait_cnt - 1;
    end else begin
      if (ram_we_l) begin
        ram[ram_a]         <= ram_wd[9:0];
        ram[ram_a | 10'd1] <= ram_wd[19:10];
      end else begin
        ram_rdat <= {ram[ram_a | 10'd1], ram[ram_a]};
      end
      mem_ready <= 1'b1;
      ram_busy  <= 1'b0;
    end
  end

  // ---------------- bus monitor ----------------
  int          req_pulses;
  logic        prev_req;
  logic [19:0] wbus;

  always @(negedge clk) begin
    if (mem_req) begin
      req_pulses++;
      check_eq("req_back_to_back", prev_req, 1'b0);
    end
    if (mem_we) wbus = mem_data;
    prev_req = mem_req;
  end

  // ---------------- reference model ----------------
  logic [9:0] gold [1024];   // what memory should hold (cache is transparent)
  bit         mvalid [8];
  int         mtag   [8];
  int         mhit;
  int         mmiss;

  function automatic int sat(input int c);
    return (c >= (1 << CW) - 1) ? c : c + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
    mhit  = 0;
    mmiss = 0;
  endtask

  task automatic do_op(input logic we, input logic [9:0] addr, input logic [9:0] wd,
                       input bit lat_chk);
    int       idx;
    int       tg;
    int       exp_lat;
    int       exp_pulses;
    int       busy;
    bit       hit;
    logic [9:0] line;
    idx  = int'(addr[3:1]);
    tg   = int'(addr[9:4]);
    line = {addr[9:1], 1'b0};
    hit  = mvalid[idx] && (mtag[idx] == tg);
    if (we) begin
      exp_lat    = hit ? 4 : 7;
      exp_pulses = hit ? 1 : 2;
    end else begin
      exp_lat    = hit ? 1 : 4;
      exp_pulses = hit ? 0 : 1;
    end

    @(negedge clk);
    cpu_req    = 1'b1;
    cpu_we     = we;
    cpu_addr   = addr;
    cpu_wdata  = wd;
    req_pulses = 0;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    busy = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (cpu_ready) break;
      busy++;
    end
    if (busy >= 100) begin
      check_eq("op_timeout", 1, 0);
      return;
    end

    if (!we) check_eq("rdata", cpu_rdata, gold[addr]);
    if (hit) mhit = sat(mhit);
    else     mmiss = sat(mmiss);
    mvalid[idx] = 1'b1;
    mtag[idx]   = tg;
    if (we) gold[addr] = wd;

    check_eq("hit_cnt", hit_cnt, mhit);
    check_eq("miss_cnt", miss_cnt, mmiss);
    check_eq("req_pulses", req_pulses, exp_pulses);
    if (exp_pulses > 0) check_eq("mem_addr", mem_addr, line);
    if (lat_chk) check_eq("busy_cycles", busy, exp_lat);
    if (we) begin
      check_eq("ram_word0", ram[line], gold[line]);
      check_eq("ram_word1", ram[line | 10'd1], gold[line | 10'd1]);
      check_eq("mem_we_released", mem_we, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [9:0] a;
    cpu_req      = 1'b0;
    cpu_we       = 1'b0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    rst_n        = 1'b0;
    mem_ready    = 1'b1;
    ram_busy     = 1'b0;
    ram_rdat     = '0;
    ram_a        = '0;
    ram_we_l     = 1'b0;
    ram_wd       = '0;
    ram_wait_cfg = 0;
    ram_wait_cnt = 0;
    req_pulses   = 0;
    prev_req     = 1'b0;
    wbus         = '0;
    for (int i = 0; i < 1024; i++) ram[i] = 10'($urandom);
    ram[0]  = 10'd22;
    ram[1]  = 10'd10;
    ram[2]  = 10'd21;
    ram[3]  = 10'd0;
    ram[16] = 10'd15;
    for (int i = 0; i < 1024; i++) gold[i] = ram[i];
    model_reset();

    repeat (3) @(negedge clk);
    check_eq("rst_cpu_ready", cpu_ready, 1'b1);
    check_eq("rst_cpu_rdata", cpu_rdata, 10'd0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 10'd0);
    check_eq("rst_hit_cnt", hit_cnt, 0);
    check_eq("rst_miss_cnt", miss_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed scenarios.
    do_op(1'b0, 10'h000, 10'h000, 1'b1);   // read miss -> 22
    do_op(1'b0, 10'h001, 10'h000, 1'b1);   // read hit  -> 10
    do_op(1'b1, 10'h002, 10'h155, 1'b1);   // write miss, 7 cycles
    do_op(1'b0, 10'h003, 10'h000, 1'b1);   // read hit  -> 0
    do_op(1'b0, 10'h010, 10'h000, 1'b1);   // conflict miss -> 15
    do_op(1'b0, 10'h000, 10'h000, 1'b1);   // miss again -> 22
    do_op(1'b1, 10'h001, 10'h3FF, 1'b1);   // write hit, 4 cycles
    check_eq("write_bus_line", wbus, {10'h3FF, 10'd22});

    // Reset during RD_ACK of a read miss.
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 10'h020;
    @(posedge clk);          // into LOOKUP
    #1 cpu_req = 1'b0;
    @(posedge clk);          // into RD_REQ
    @(posedge clk);          // into RD_ACK
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_mem_req", mem_req, 1'b0);
    check_eq("abort_mem_we", mem_we, 1'b0);
    check_eq("abort_cpu_ready", cpu_ready, 1'b1);
    check_eq("abort_miss_cnt", miss_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_op(1'b0, 10'h001, 10'h000, 1'b1);   // valid cleared -> miss, 0x3FF

    // Random traffic; second half lets the RAM stretch its handshake.
    for (int i = 0; i < 300; i++) begin
      ram_wait_cfg = (i >= 150) ? int'($urandom_range(0, 3)) : 0;
      a = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 63));
      do_op(1'($urandom_range(0, 1)), a, 10'($urandom), ram_wait_cfg == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
